// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: shifts a WIDTH-bit pattern out MSB-first over a valid/ready load,
// optionally repeating it with a fixed idle gap between frames.
module seq_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int GAP   = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_repeat,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP_S} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n, pat, pat_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [CNT_W-1:0] rep_cnt, rep_n;
    logic [GW-1:0]    gap_cnt, gap_n;

    assign load_ready = state == IDLE;

    // shreg[WIDTH-1] is always the bit on the wire while in SHIFT
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        pat_n   = pat;
        bit_n   = bit_cnt;
        rep_n   = rep_cnt;
        gap_n   = gap_cnt;
        case (state)
            IDLE: if (load_valid) begin
                state_n = SHIFT;
                shreg_n = load_data;
                pat_n   = load_data;
                rep_n   = load_repeat;
                bit_n   = '0;
            end
            SHIFT: if (bit_cnt == BW'(WIDTH - 1)) begin
                bit_n   = '0;
                shreg_n = shreg << 1;
                if (rep_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    rep_n   = rep_cnt - 1'b1;
                    shreg_n = pat;
                    gap_n   = '0;
                    state_n = GAP == 0 ? SHIFT : GAP_S;
                end
            end else begin
                bit_n   = bit_cnt + 1'b1;
                shreg_n = shreg << 1;
            end
            GAP_S: if (int'(gap_cnt) == GAP - 1) state_n = SHIFT;
                   else gap_n = gap_cnt + 1'b1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            shreg     <= '0;
            pat       <= '0;
            bit_cnt   <= '0;
            rep_cnt   <= '0;
            gap_cnt   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            pat       <= pat_n;
            bit_cnt   <= bit_n;
            rep_cnt   <= rep_n;
            gap_cnt   <= gap_n;
            out       <= state_n == SHIFT && shreg_n[WIDTH-1];
            out_valid <= state_n == SHIFT;
            busy      <= state_n != IDLE;
            done      <= state_n == SHIFT && bit_n == BW'(WIDTH - 1) && rep_n == '0;
        end
    end
endmodule
